scan_addr_check: RTL and testbench

Receive side of the 2D scan address stream. Consumes the 32-bit addresses emitted by the scan generator and re-derives the expected sequence from the same configuration (`x_delta`, `x_max`, `y_delta`, `y_max`). Decodes every accepted address into (x, y) step indices with row/frame markers and flags any address that departs from the expected sequence. Sits between the generator's registered `addr` output and the memory-side consumer, behind a valid/ready handshake.

---
 rtl/scan_addr_check_if.sv | 29 ++
 rtl/scan_addr_check.sv | 136 +++++++++++++
 tb/tb_scan_addr_check.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/scan_addr_check_if.sv
// Handshake bundle for scan_addr_check: address beats in, decoded beats out.
interface scan_addr_check_if #(
  parameter int XW = 16,
  parameter int YW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_addr;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_addr;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic          out_row_end;
  logic          out_frame_end;
  logic          out_mismatch;

  modport master (
    output in_valid, in_addr, out_ready,
    input  in_ready, out_valid, out_addr, out_x, out_y,
           out_row_end, out_frame_end, out_mismatch
  );

  modport slave (
    input  in_valid, in_addr, out_ready,
    output in_ready, out_valid, out_addr, out_x, out_y,
           out_row_end, out_frame_end, out_mismatch
  );
endinterface

// File: rtl/scan_addr_check.sv
// scan_addr_check - re-derives the 2D scan address sequence, decodes each beat
// into (x, y) with row/frame markers and flags departures from the sequence.
module scan_addr_check #(
  parameter int XW = 16,
  parameter int YW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [11:0]       x_delta,
  input  logic [31:0]       x_max,
  input  logic [31:0]       y_delta,
  input  logic [31:0]       y_max,
  scan_addr_check_if.slave  bus,
  output logic              err_sticky,
  output logic [15:0]       err_count
);
  typedef enum logic {S_IDLE, S_TRACK} state_t;

  localparam logic [XW-1:0] X_ONE = {{(XW-1){1'b0}}, 1'b1};
  localparam logic [YW-1:0] Y_ONE = {{(YW-1){1'b0}}, 1'b1};

  state_t        r_state;
  logic [11:0]   r_x_delta;
  logic [31:0]   r_x_max;
  logic [31:0]   r_y_delta;
  logic [31:0]   r_y_max;
  logic [31:0]   r_exp;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_err_sticky;
  logic [15:0]   r_err_count;
  logic          r_out_valid;
  logic [31:0]   r_out_addr;
  logic [XW-1:0] r_out_x;
  logic [YW-1:0] r_out_y;
  logic          r_out_row_end;
  logic          r_out_frame_end;
  logic          r_out_mismatch;

  logic [11:0]   w_s_lo;
  logic          w_row;
  logic [31:0]   w_n;
  logic          w_wrap;
  logic [31:0]   w_next;
  logic          w_mismatch;
  logic          w_accept;

  // Only the low 12 bits of a + x_delta feed the row test, so the sum is kept narrow.
  assign w_s_lo     = bus.in_addr[11:0] + r_x_delta;
  assign w_row      = ({20'b0, w_s_lo} == r_x_max);
  assign w_n        = bus.in_addr + (w_row ? r_y_delta : {20'b0, r_x_delta});
  assign w_wrap     = (w_n == r_y_max);
  assign w_next     = w_wrap ? 32'd0 : w_n;
  assign w_mismatch = (bus.in_addr != r_exp);

  assign bus.in_ready = (r_state == S_TRACK) & ~start & (~r_out_valid | bus.out_ready);
  assign w_accept     = bus.in_valid & bus.in_ready;

  assign bus.out_valid     = r_out_valid;
  assign bus.out_addr      = r_out_addr;
  assign bus.out_x         = r_out_x;
  assign bus.out_y         = r_out_y;
  assign bus.out_row_end   = r_out_row_end;
  assign bus.out_frame_end = r_out_frame_end;
  assign bus.out_mismatch  = r_out_mismatch;
  assign err_sticky        = r_err_sticky;
  assign err_count         = r_err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_x_delta       <= '0;
      r_x_max         <= '0;
      r_y_delta       <= '0;
      r_y_max         <= '0;
      r_exp           <= '0;
      r_x             <= '0;
      r_y             <= '0;
      r_err_sticky    <= 1'b0;
      r_err_count     <= '0;
      r_out_valid     <= 1'b0;
      r_out_addr      <= '0;
      r_out_x         <= '0;
      r_out_y         <= '0;
      r_out_row_end   <= 1'b0;
      r_out_frame_end <= 1'b0;
      r_out_mismatch  <= 1'b0;
    end else if (start) begin
      r_state         <= S_TRACK;
      r_x_delta       <= x_delta;
      r_x_max         <= x_max;
      r_y_delta       <= y_delta;
      r_y_max         <= y_max;
      r_exp           <= '0;
      r_x             <= '0;
      r_y             <= '0;
      r_err_sticky    <= 1'b0;
      r_err_count     <= '0;
      r_out_valid     <= 1'b0;
      r_out_addr      <= '0;
      r_out_x         <= '0;
      r_out_y         <= '0;
      r_out_row_end   <= 1'b0;
      r_out_frame_end <= 1'b0;
      r_out_mismatch  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid     <= 1'b1;
      r_out_addr      <= bus.in_addr;
      r_out_x         <= r_x;
      r_out_y         <= r_y;
      r_out_row_end   <= w_row;
      r_out_frame_end <= w_wrap;
      r_out_mismatch  <= w_mismatch;
      // Always resync to what was received so a single bad beat costs one error.
      r_exp           <= w_next;
      if (w_wrap) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_row) begin
        r_x <= '0;
        r_y <= r_y + Y_ONE;
      end else begin
        r_x <= r_x + X_ONE;
      end
      if (w_mismatch) begin
        r_err_sticky <= 1'b1;
        if (r_err_count != 16'hFFFF) begin
          r_err_count <= r_err_count + 16'd1;
        end
      end
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_scan_addr_check.sv
// tb_scan_addr_check - scoreboard bench: directed test-plan cases plus randomized streams.
module tb_scan_addr_check;
  localparam int XW = 16;
  localparam int YW = 16;
  localparam longint M32 = 64'h1_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] x_delta = '0;
  logic [31:0] x_max = '0;
  logic [31:0] y_delta = '0;
  logic [31:0] y_max = '0;
  logic        err_sticky;
  logic [15:0] err_count;

  scan_addr_check_if #(.XW(XW), .YW(YW)) bus ();

  scan_addr_check #(.XW(XW), .YW(YW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x_delta(x_delta), .x_max(x_max), .y_delta(y_delta), .y_max(y_max),
    .bus(bus), .err_sticky(err_sticky), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int x; int y;
    bit row; bit frame; bit mis; bit sticky;
    int cnt;
  } beat_t;

  beat_t  q[$];
  int     chk_cnt = 0;
  int     pass_cnt = 0;
  bit     flush = 1'b0;
  bit     rr_en = 1'b0;
  longint c_xd, c_xm, c_yd, c_ym;
  longint m_exp;
  int     m_x, m_y, m_cnt;
  bit     m_sticky;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    chk_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
  endtask

  function automatic bit is_row(longint a, longint xd, longint xm);
    return (((a + xd) % M32) % 4096) == xm;
  endfunction

  function automatic longint step(longint a, longint xd, longint xm, longint yd);
    return (a + (is_row(a, xd, xm) ? yd : xd)) % M32;
  endfunction

  task automatic model_reset();
    c_xd = longint'(x_delta); c_xm = longint'(x_max);
    c_yd = longint'(y_delta); c_ym = longint'(y_max);
    m_exp = 0; m_x = 0; m_y = 0; m_cnt = 0; m_sticky = 1'b0;
  endtask

  task automatic model_accept(input logic [31:0] a);
    beat_t  b;
    longint n;
    n = step(longint'(a), c_xd, c_xm, c_yd);
    b.addr  = a; b.x = m_x; b.y = m_y;
    b.row   = is_row(longint'(a), c_xd, c_xm);
    b.frame = (n == c_ym);
    b.mis   = (longint'(a) != m_exp);
    if (b.mis) begin
      m_sticky = 1'b1;
      if (m_cnt < 65535) m_cnt++;
    end
    b.sticky = m_sticky; b.cnt = m_cnt;
    m_exp = b.frame ? 0 : n;
    if (b.frame) begin m_x = 0; m_y = 0; end
    else if (b.row) begin m_x = 0; m_y = (m_y + 1) % (1 << YW); end
    else m_x = (m_x + 1) % (1 << XW);
    q.push_back(b);
  endtask

  // Caller is at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] a);
    int budget = 200;
    bus.in_valid = 1'b1;
    bus.in_addr  = a;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        model_accept(a);
        break;
      end
      budget--;
      if (budget == 0) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_start(input logic [11:0] xd, input logic [31:0] xm, input logic [31:0] yd, input logic [31:0] ym);
    x_delta = xd; x_max = xm; y_delta = yd; y_max = ym;
    bus.in_valid = 1'b0;
    start = 1'b1;
    flush = 1'b1;
    q.delete();
    model_reset();
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b0;
    check("start_out_valid", bus.out_valid, 0);
    check("start_err_sticky", err_sticky, 0);
    check("start_err_count", err_count, 0);
    // Config inputs are scrambled afterwards; the DUT must use the latched copy.
    x_delta = 12'hABC; x_max = 32'hDEAD; y_delta = 32'h77; y_max = 32'h1234;
  endtask

  // Monitor: pops on transfer, compares held beat against front while stalled.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!flush && bus.out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = q[0];
          check("beat", {bus.out_addr, 16'(bus.out_x), 16'(bus.out_y), bus.out_row_end,
                         bus.out_frame_end, bus.out_mismatch, err_sticky, err_count},
                        {e.addr, 16'(e.x), 16'(e.y), e.row, e.frame, e.mis, e.sticky, 16'(e.cnt)});
          if (bus.out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rr_en) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    longint a;
    bus.in_valid = 1'b0; bus.in_addr = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", bus.in_ready, 0);
    check("reset_outputs", {bus.out_valid, bus.out_addr, 16'(bus.out_x), 16'(bus.out_y),
                            bus.out_row_end, bus.out_frame_end, bus.out_mismatch, err_sticky, err_count}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;

    do_start(12'd1, 32'd4, 32'd1, 32'd6);
    foreach (q[i]) begin end
    for (int i = 0; i < 7; i++) send((i == 6) ? 32'd0 : 32'(i));
    repeat (2) @(posedge clk); #1;

    do_start(12'd1, 32'd4, 32'd1, 32'd6);
    send(32'd0); send(32'd1); send(32'd7); send(32'd8);
    repeat (2) @(posedge clk); #1;
    check("err_count_after_7_8", err_count, 1);

    do_start(12'd1, 32'd4, 32'd1, 32'd6);
    send(32'd0);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_addr   = 32'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_in_ready", bus.in_ready, 0);
      check("hold_out_addr", {bus.out_valid, bus.out_addr}, {1'b1, 32'd0});
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(32'd1); send(32'd2);
    repeat (2) @(posedge clk); #1;

    do_start(12'd1, 32'd4, 32'd2, 32'd5);
    send(32'd0); send(32'd1); send(32'd2); send(32'd3); send(32'd0);
    repeat (2) @(posedge clk); #1;

    do_start(12'd1, 32'd4, 32'd1, 32'd6);
    send(32'd0); send(32'd5);
    bus.out_ready = 1'b0;
    check("stall_before_start", {bus.out_valid, err_sticky}, 2'b11);
    do_start(12'd1, 32'd4, 32'd1, 32'd6);
    bus.out_ready = 1'b1;
    send(32'd0); send(32'd1);
    repeat (2) @(posedge clk); #1;

    do_start(12'd1, 32'd4, 32'd1, 32'd6);
    send(32'd0); send(32'd1); send(32'd9);
    #2;
    flush = 1'b1;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("async_reset_outputs", {bus.in_ready, bus.out_valid, bus.out_addr, 16'(bus.out_x), 16'(bus.out_y),
                                  bus.out_row_end, bus.out_frame_end, bus.out_mismatch, err_sticky, err_count}, 0);
    bus.in_valid = 1'b1; bus.in_addr = 32'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_reset_idle", {bus.in_ready, bus.out_valid}, 0);
    end
    @(posedge clk); #1;
    flush = 1'b0;

    for (int r = 0; r < 3; r++) begin
      logic [11:0] xd;
      logic [31:0] xm, yd;
      xd = 12'($urandom_range(1, 5));
      xm = 32'(xd) * 32'($urandom_range(2, 8));
      yd = 32'($urandom_range(16, 64));
      a = 0;
      for (int k = 0; k < int'($urandom_range(6, 40)); k++) a = step(a, xd, xm, yd);
      do_start(xd, xm, yd, 32'(a));
      rr_en = 1'b1;
      for (int i = 0; i < 250; i++) begin
        if ($urandom_range(0, 9) == 0) send($urandom);
        else send(32'(m_exp));
        if ($urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
      end
      rr_en = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20 && q.size() != 0; i++) begin @(posedge clk); #1; end
      check("drain_empty", q.size(), 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
